// File: rtl/pc_next_ctrl_pkg.sv
// Shared encodings for the next-PC controller: control-flow kinds, PC source
// mux selector codes, exception cause codes and the controller state type.
package pc_next_ctrl_pkg;

    localparam logic [2:0] KIND_SEQ  = 3'd0;
    localparam logic [2:0] KIND_BEQ  = 3'd1;
    localparam logic [2:0] KIND_BNE  = 3'd2;
    localparam logic [2:0] KIND_BLE  = 3'd3;
    localparam logic [2:0] KIND_BGT  = 3'd4;
    localparam logic [2:0] KIND_JUMP = 3'd5;
    localparam logic [2:0] KIND_JR   = 3'd6;
    localparam logic [2:0] KIND_RSV  = 3'd7;

    // Must track the PC source mux input ordering in the datapath.
    localparam logic [2:0] PCSRC_PC4 = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_JMP = 3'b010;
    localparam logic [2:0] PCSRC_REG = 3'b011;
    localparam logic [2:0] PCSRC_EXC = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_EXT     = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StWaitFlags,
        StCommit,
        StExc
    } pc_state_e;

    function automatic logic is_branch(input logic [2:0] kind);
        return (kind >= KIND_BEQ) && (kind <= KIND_BGT);
    endfunction

endpackage

// File: rtl/pc_next_ctrl_branch_eval.sv
// Combinational branch resolution: decides whether a conditional branch is
// taken from its kind and the ALU zero / signed greater-than flags.
module pc_next_ctrl_branch_eval
    import pc_next_ctrl_pkg::*;
(
    input  logic [2:0] i_kind,
    input  logic       i_zero,
    input  logic       i_gt,
    output logic       o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_kind)
            KIND_BEQ: o_taken = i_zero;
            KIND_BNE: o_taken = !i_zero;
            KIND_BLE: o_taken = i_zero || !i_gt;
            KIND_BGT: o_taken = i_gt && !i_zero;
            default:  o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_next_ctrl.sv
// Next-PC controller for the multicycle datapath: drives the PC source mux and
// PC/EPC write strobes. Exceptions are compiled in with `define PC_NEXT_EXC_EN.
module pc_next_ctrl
    import pc_next_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_instr_valid,
    input  logic [2:0] i_kind,
    input  logic       i_flags_valid,
    input  logic       i_zero,
    input  logic       i_gt,
    input  logic       i_exc_req,
    output logic [2:0] o_pc_src,
    output logic       o_pc_write,
    output logic       o_epc_write,
    output logic [1:0] o_exc_cause,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned   TW         = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

`ifdef PC_NEXT_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    pc_state_e     r_state, w_state_d;
    logic [2:0]    r_kind, w_kind_d;
    logic [TW-1:0] r_timer, w_timer_d;
    logic [2:0]    w_src_d, w_pc_src_d;
    logic [1:0]    w_cause_d;
    logic [2:0]    r_pc_src;
    logic          r_pc_write, r_done, r_busy;
    logic          w_exc, w_taken, w_fire;

    assign w_exc = EXC_EN && i_exc_req;

    pc_next_ctrl_branch_eval u_branch_eval (
        .i_kind  (r_kind),
        .i_zero  (i_zero),
        .i_gt    (i_gt),
        .o_taken (w_taken)
    );

    always_comb begin
        w_state_d = r_state;
        w_kind_d  = r_kind;
        w_timer_d = r_timer;
        w_src_d   = PCSRC_PC4;
        w_cause_d = CAUSE_NONE;
        unique case (r_state)
            StIdle: begin
                if (w_exc) begin
                    w_state_d = StExc;
                    w_cause_d = CAUSE_EXT;
                end else if (i_instr_valid) begin
                    w_kind_d = i_kind;
                    if (is_branch(i_kind)) begin
                        w_state_d = StWaitFlags;
                        w_timer_d = '0;
                    end else if (i_kind == KIND_RSV && EXC_EN) begin
                        w_state_d = StExc;
                        w_cause_d = CAUSE_ILLEGAL;
                    end else begin
                        w_state_d = StCommit;
                        if (i_kind == KIND_JUMP)    w_src_d = PCSRC_JMP;
                        else if (i_kind == KIND_JR) w_src_d = PCSRC_REG;
                    end
                end
            end
            StWaitFlags: begin
                if (w_exc) begin
                    w_state_d = StExc;
                    w_cause_d = CAUSE_EXT;
                end else if (i_flags_valid) begin
                    w_state_d = StCommit;
                    w_src_d   = w_taken ? PCSRC_BR : PCSRC_PC4;
                end else if (r_timer == TIMER_LAST) begin
                    // Without exceptions a lost flag pulse falls through as not-taken.
                    w_state_d = EXC_EN ? StExc : StCommit;
                    w_cause_d = CAUSE_TIMEOUT;
                end else begin
                    w_timer_d = r_timer + 1'b1;
                end
            end
            StCommit, StExc: w_state_d = StIdle;
            default:         w_state_d = StIdle;
        endcase
    end

    assign w_fire     = (w_state_d == StCommit) || (w_state_d == StExc);
    assign w_pc_src_d = (w_state_d == StExc)    ? PCSRC_EXC :
                        (w_state_d == StCommit) ? w_src_d   : PCSRC_PC4;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_kind     <= KIND_SEQ;
            r_timer    <= '0;
            r_pc_src   <= PCSRC_PC4;
            r_pc_write <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_kind     <= w_kind_d;
            r_timer    <= w_timer_d;
            r_pc_src   <= w_pc_src_d;
            r_pc_write <= w_fire;
            r_done     <= w_fire;
            r_busy     <= (w_state_d != StIdle);
        end
    end

    assign o_pc_src   = r_pc_src;
    assign o_pc_write = r_pc_write;
    assign o_done     = r_done;
    assign o_busy     = r_busy;

`ifdef PC_NEXT_EXC_EN
    logic       r_epc_write;
    logic [1:0] r_exc_cause;

    // Cause is sticky until the next exception so software can read it late.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_epc_write <= 1'b0;
            r_exc_cause <= CAUSE_NONE;
        end else begin
            r_epc_write <= (w_state_d == StExc);
            if (w_state_d == StExc) r_exc_cause <= w_cause_d;
        end
    end

    assign o_epc_write = r_epc_write;
    assign o_exc_cause = r_exc_cause;
`else
    logic w_unused;
    assign w_unused    = ^{i_exc_req, w_cause_d};
    assign o_epc_write = 1'b0;
    assign o_exc_cause = CAUSE_NONE;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Self-checking bench for pc_next_ctrl: directed scenarios plus random traffic
// against a transaction-level reference model. Honors `define PC_NEXT_EXC_EN.
module tb_pc_next_ctrl;

    localparam int unsigned TIMEOUT = 15;
`ifdef PC_NEXT_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [2:0] kind = 3'd0;
    logic       flags_valid = 1'b0;
    logic       zero = 1'b0;
    logic       gt = 1'b0;
    logic       exc_req = 1'b0;
    logic [2:0] pc_src;
    logic       pc_write, epc_write, busy, done;
    logic [1:0] exc_cause;

    always #5 clk = ~clk;

    pc_next_ctrl #(.TIMEOUT(TIMEOUT)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_instr_valid (instr_valid),
        .i_kind        (kind),
        .i_flags_valid (flags_valid),
        .i_zero        (zero),
        .i_gt          (gt),
        .i_exc_req     (exc_req),
        .o_pc_src      (pc_src),
        .o_pc_write    (pc_write),
        .o_epc_write   (epc_write),
        .o_exc_cause   (exc_cause),
        .o_busy        (busy),
        .o_done        (done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    // Reference model: one pending instruction, tracked by how long it has waited.
    bit m_wait, m_pulse;
    int m_kind, m_age, m_cause;
    int e_src, e_pw, e_epc, e_busy, e_done, e_cause;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit br_taken(input int k, input bit z, input bit g);
        // BLE/BGT compare the ALU difference against zero as a signed value.
        case (k)
            1:       return z;
            2:       return !z;
            3:       return z || !g;
            4:       return g && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_wait = 0; m_pulse = 0; m_kind = 0; m_age = 0; m_cause = 0;
        e_src = 0; e_pw = 0; e_epc = 0; e_busy = 0; e_done = 0; e_cause = 0;
    endtask

    task automatic model_step(input bit iv, input int k, input bit fv, input bit z,
                              input bit g, input bit ex);
        bit fire = 0;
        bit to_exc = 0;
        int src = 0;
        int cause = 0;
        if (m_pulse) begin
            m_pulse = 0;
        end else if (m_wait) begin
            if (EXC_EN && ex) begin
                fire = 1; to_exc = 1; cause = 3;
            end else if (fv) begin
                fire = 1; src = br_taken(m_kind, z, g) ? 1 : 0;
            end else if (m_age == TIMEOUT - 1) begin
                fire = 1;
                if (EXC_EN) begin to_exc = 1; cause = 2; end
            end else begin
                m_age++;
            end
            if (fire) m_wait = 0;
        end else if (EXC_EN && ex) begin
            fire = 1; to_exc = 1; cause = 3;
        end else if (iv) begin
            if (k >= 1 && k <= 4) begin
                m_wait = 1; m_age = 0; m_kind = k;
            end else if (k == 7) begin
                fire = 1;
                if (EXC_EN) begin to_exc = 1; cause = 1; end
            end else begin
                fire = 1;
                src  = (k == 5) ? 2 : (k == 6) ? 3 : 0;
            end
        end
        if (to_exc) begin
            src = 4;
            m_cause = cause;
        end
        m_pulse = fire;
        e_pw = fire; e_done = fire; e_epc = to_exc; e_src = src;
        e_busy = m_wait || m_pulse; e_cause = m_cause;
    endtask

    task automatic check_all(input string tag);
        string t;
        t = $sformatf("%s@%0d", tag, cyc_no);
        check_val({t, ".pc_src"},    32'(pc_src),    32'(e_src));
        check_val({t, ".pc_write"},  32'(pc_write),  32'(e_pw));
        check_val({t, ".epc_write"}, 32'(epc_write), 32'(e_epc));
        check_val({t, ".exc_cause"}, 32'(exc_cause), 32'(e_cause));
        check_val({t, ".busy"},      32'(busy),      32'(e_busy));
        check_val({t, ".done"},      32'(done),      32'(e_done));
    endtask

    task automatic cyc(input string tag, input bit iv, input int k, input bit fv,
                       input bit z, input bit g, input bit ex);
        instr_valid = iv; kind = 3'(k); flags_valid = fv; zero = z; gt = g; exc_req = ex;
        model_step(iv, k, fv, z, g, ex);
        @(posedge clk);
        #1;
        cyc_no++;
        check_all(tag);
        instr_valid = 0; flags_valid = 0; exc_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc("idle", 0, 0, 0, 0, 0, 0);
    endtask

    int pulses;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Jump commits one cycle after accept, idle one cycle later.
        idle(6);
        cyc("jump", 1, 5, 0, 0, 0, 0);
        check_val("jump.src", 32'(pc_src), 32'd2);
        idle(1);
        check_val("jump.busy_after", 32'(busy), 32'd0);

        // BEQ taken / not taken, flags four cycles after accept.
        for (int z = 1; z >= 0; z--) begin
            cyc("beq", 1, 1, 0, 0, 0, 0);
            idle(3);
            cyc("beq.flags", 0, 0, 1, z[0], 0, 0);
            check_val("beq.src", 32'(pc_src), (z == 1) ? 32'd1 : 32'd0);
            idle(2);
        end

        // BGT with no flags: the pulse lands on the TIMEOUT-th waiting cycle.
        cyc("bgt", 1, 4, 0, 0, 0, 0);
        idle(TIMEOUT);
        check_val("tmo.pc_write", 32'(pc_write), 32'd1);
        check_val("tmo.src", 32'(pc_src), EXC_EN ? 32'd4 : 32'd0);
        check_val("tmo.cause", 32'(exc_cause), EXC_EN ? 32'd2 : 32'd0);
        idle(2);

        // Flags arriving on the last waiting cycle beat the timeout.
        cyc("ble", 1, 3, 0, 0, 0, 0);
        idle(TIMEOUT - 1);
        cyc("ble.flags", 0, 0, 1, 0, 0, 0);
        check_val("edge.src", 32'(pc_src), 32'd1);
        check_val("edge.epc", 32'(epc_write), 32'd0);
        idle(2);

        // exc_req and flags_valid together.
        cyc("bne", 1, 2, 0, 0, 0, 0);
        idle(1);
        cyc("bne.exc", 0, 0, 1, 0, 0, 1);
        check_val("excpri.src", 32'(pc_src), EXC_EN ? 32'd4 : 32'd1);
        check_val("excpri.cause", 32'(exc_cause), EXC_EN ? 32'd3 : 32'd0);
        idle(2);

        // JR with a second instr_valid while busy: exactly one commit.
        pulses = 0;
        cyc("jr", 1, 6, 0, 0, 0, 0);
        pulses += int'(pc_write);
        check_val("jr.src", 32'(pc_src), 32'd3);
        cyc("jr.busy", 1, 5, 0, 0, 0, 0);
        pulses += int'(pc_write);
        check_val("jr.pulses", 32'(pulses), 32'd1);

        // Reserved kind, then back-to-back accept in the first idle cycle.
        cyc("rsv", 1, 7, 0, 0, 0, 0);
        idle(1);
        cyc("b2b.a", 1, 0, 0, 0, 0, 0);
        cyc("b2b.drop", 1, 5, 0, 0, 0, 0);
        cyc("b2b.b", 1, 6, 0, 0, 0, 0);
        idle(2);

        // Reset while waiting drops the branch; no later commit appears.
        cyc("pre_rst", 1, 2, 0, 0, 0, 0);
        idle(2);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TIMEOUT + 3; i++) cyc("post_rst", 0, 0, 1, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc("rnd",
                $urandom_range(0, 99) < 30,
                int'($urandom_range(0, 7)),
                $urandom_range(0, 99) < 12,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                $urandom_range(0, 99) < 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
